add_seq_ctrl: RTL

//   Multi-cycle controller that sequences one shared 8-bit ripple-carry adder (external, add-only)
//   to perform WIDTH = 8*NUM_BYTES add/subtract, one byte per cycle, LSB first.

---
 rtl/add_seq_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/add_seq_ctrl.sv
// Byte-serial add/subtract controller: drives one shared external 8-bit adder
// LSB-first over NUM_BYTES cycles and reports the result with C/V/N/Z flags.
module add_seq_ctrl #(
  parameter int NUM_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_a,
  input  logic [8*NUM_BYTES-1:0] in_b,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_result,
  output logic                   out_c,
  output logic                   out_v,
  output logic                   out_n,
  output logic                   out_z,
  output logic [7:0]             adder_a,
  output logic [7:0]             adder_b,
  output logic                   adder_cin,
  input  logic [7:0]             adder_sum,
  input  logic                   adder_cout,
  output logic [1:0]             dbg_state
);

  localparam int WIDTH = 8 * NUM_BYTES;
  localparam int IW    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, result_q;
  logic              sub_q, carry_q, c_q, v_q;
  logic [IW-1:0]     idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)      state_d = RUN;
      RUN:     if (idx_q == LAST) state_d = DONE;
      DONE:    if (out_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    adder_a   = 8'h00;
    adder_b   = 8'h00;
    adder_cin = 1'b0;
    if (state_q == RUN) begin
      adder_a   = a_q[{idx_q, 3'b000} +: 8];
      adder_b   = b_q[{idx_q, 3'b000} +: 8];
      // The first byte's carry-in is the +1 that completes two's-complement subtraction.
      adder_cin = (idx_q == '0) ? sub_q : carry_q;
    end
  end

  // b_q holds B already inverted for subtraction, so the overflow test is the
  // same same-sign-in / different-sign-out rule for both operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        a_q   <= in_a;
        b_q   <= in_b ^ {WIDTH{in_sub}};
        sub_q <= in_sub;
        idx_q <= '0;
      end else if (state_q == RUN) begin
        result_q[{idx_q, 3'b000} +: 8] <= adder_sum;
        carry_q <= adder_cout;
        idx_q   <= idx_q + IW'(1);
        if (idx_q == LAST) begin
          c_q <= adder_cout;
          v_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (adder_sum[7] != a_q[WIDTH-1]);
        end
      end
    end
  end

  assign out_result = result_q;
  assign out_c      = c_q;
  assign out_v      = v_q;
  assign out_n      = result_q[WIDTH-1];
  assign out_z      = (result_q == '0);
  assign dbg_state  = state_q;

endmodule
